// File: rtl/qr_pkg.sv
// rtl/qr_pkg.sv - shared constants and types for the QR R-matrix collector
package qr_pkg;
    localparam int MAT_INT     = 8;
    localparam int MAT_FRAC    = 3;
    localparam int DATA_W      = MAT_INT + MAT_FRAC + 1;
    localparam int N           = 4;
    localparam int DET_W       = N * DATA_W;
    localparam int FRAME_WORDS = N * N;
    localparam int ROW_W       = $clog2(N);
    localparam int IDX_W       = 2 * ROW_W;

    typedef logic signed [DATA_W-1:0] r_word_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DROP
    } wr_state_t;
endpackage

// File: rtl/qr_pingpong_ram.sv
// rtl/qr_pingpong_ram.sv - two-bank frame store, word write port and row read port
//
// Ports:
//   clk                 clock
//   wr_en/wr_bank/wr_idx/wr_data  write one word at row-major index of a bank
//   rd_bank/rd_row      select a row; rd_data returns its N words, element 0 in LSBs
module qr_pingpong_ram
    import qr_pkg::*;
(
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic                   wr_bank,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_bank,
    input  logic [ROW_W-1:0]       rd_row,
    output logic [N*DATA_W-1:0]    rd_data
);

    // Contents are never reset: bank occupancy lives in the top level.
    r_word_t mem_q [2][FRAME_WORDS];
    r_word_t mem_d [2][FRAME_WORDS];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_bank][wr_idx] = r_word_t'(wr_data);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < N; c++) begin
            rd_data[c*DATA_W +: DATA_W] = mem_q[rd_bank][{rd_row, ROW_W'(c)}];
        end
    end

endmodule

// File: rtl/qr_r_collector.sv
// rtl/qr_r_collector.sv - captures serial R frames, re-emits rows, computes det(R)
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid, in_data             serial row-major R words, N*N per frame
//   out_valid, out_ready          row handshake
//   out_row, out_row_idx, out_last row data (element 0 in LSBs), row number, final row
//   det_valid, det                one-cycle pulse with product of the diagonal
//   overrun, frame_err            sticky: frame dropped / frame truncated
module qr_r_collector
    import qr_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*DATA_W-1:0]    out_row,
    output logic [ROW_W-1:0]       out_row_idx,
    output logic                   out_last,
    output logic                   det_valid,
    output logic [DET_W-1:0]       det,
    output logic                   overrun,
    output logic                   frame_err
);

    localparam logic signed [DET_W-1:0] ACC_ONE  = DET_W'(1);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [ROW_W-1:0]        LAST_ROW = ROW_W'(N - 1);

    wr_state_t                 state_q, state_d;
    logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic [ROW_W-1:0]          rd_row_q, rd_row_d;
    logic signed [DET_W-1:0]   acc_q, acc_d;
    logic signed [DET_W-1:0]   det_q, det_d;
    logic                      det_valid_q, det_valid_d;
    logic                      overrun_q, overrun_d;
    logic                      frame_err_q, frame_err_d;

    logic                      ram_we;
    logic                      commit;
    logic                      free_fire;
    logic                      bank_free;
    logic                      on_diag;
    logic signed [DET_W-1:0]   in_ext;
    logic signed [DET_W-1:0]   prod;
    logic [N*DATA_W-1:0]       ram_row;

    qr_pingpong_ram u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_bank (wr_ptr_q),
        .wr_idx  (wr_idx_q),
        .wr_data (in_data),
        .rd_bank (rd_ptr_q),
        .rd_row  (rd_row_q),
        .rd_data (ram_row)
    );

    assign out_valid   = (count_q != 2'd0);
    assign out_row     = out_valid ? ram_row : '0;
    assign out_row_idx = rd_row_q;
    assign out_last    = out_valid && (rd_row_q == LAST_ROW);
    assign det_valid   = det_valid_q;
    assign det         = det_q;
    assign overrun     = overrun_q;
    assign frame_err   = frame_err_q;

    assign free_fire = out_last && out_ready;
    // A bank emptied by the reader this cycle is reusable by a frame starting now.
    assign bank_free = (count_q < 2'd2) || free_fire;
    // Diagonal element: row index equals column index.
    assign on_diag   = (wr_idx_q[IDX_W-1:ROW_W] == wr_idx_q[ROW_W-1:0]);
    assign in_ext    = {{(DET_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign prod      = on_diag ? (acc_q * in_ext) : acc_q;

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_row_d    = rd_row_q;
        acc_d       = acc_q;
        det_d       = det_q;
        det_valid_d = 1'b0;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        ram_we      = 1'b0;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (bank_free) begin
                        state_d = FILL;
                        ram_we  = 1'b1;
                    end else begin
                        state_d   = DROP;
                        overrun_d = 1'b1;
                    end
                end
            end
            FILL: ram_we = in_valid;
            DROP: ;
            default: state_d = IDLE;
        endcase

        // Every in_valid cycle consumes one word, whether stored or dropped.
        if (in_valid) begin
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d = '0;
                state_d  = IDLE;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end

        if (ram_we) begin
            acc_d = prod;
            if (wr_idx_q == LAST_IDX) begin
                commit      = 1'b1;
                det_d       = prod;
                det_valid_d = 1'b1;
                acc_d       = ACC_ONE;
            end
        end

        if ((state_q != IDLE) && !in_valid) begin
            state_d     = IDLE;
            wr_idx_d    = '0;
            acc_d       = ACC_ONE;
            frame_err_d = 1'b1;
        end

        if (commit) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (out_valid && out_ready) begin
            rd_row_d = free_fire ? '0 : rd_row_q + ROW_W'(1);
        end
        if (free_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, commit} - {1'b0, free_fire};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_idx_q    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            rd_row_q    <= '0;
            acc_q       <= ACC_ONE;
            det_q       <= '0;
            det_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_row_q    <= rd_row_d;
            acc_q       <= acc_d;
            det_q       <= det_d;
            det_valid_q <= det_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_qr_r_collector.sv
// tb/tb_qr_r_collector.sv - directed self-checking bench for qr_r_collector
module tb_qr_r_collector;
    import qr_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [N*DATA_W-1:0] out_row;
    logic [ROW_W-1:0]    out_row_idx;
    logic                out_last;
    logic                det_valid;
    logic [DET_W-1:0]    det;
    logic                overrun;
    logic                frame_err;

    always #5 clk = ~clk;

    qr_r_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .det_valid   (det_valid),
        .det         (det),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0]   fr [4][FRAME_WORDS];
    logic [N*DATA_W-1:0] rows_q [$];
    logic [ROW_W-1:0]    ridx_q [$];
    logic                rlast_q [$];
    int                  det_cnt = 0;
    logic [DET_W-1:0]    det_seen = '0;

    // Records accepted rows and det pulses mid-cycle, before the edge that consumes them.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                rows_q.push_back(out_row);
                ridx_q.push_back(out_row_idx);
                rlast_q.push_back(out_last);
            end
            if (det_valid) begin
                det_cnt++;
                det_seen = det;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rows_q.delete();
        ridx_q.delete();
        rlast_q.delete();
        det_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic set_frame(input int f, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                             input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3, input int base);
        logic [DATA_W-1:0] dg [4];
        dg = '{d0, d1, d2, d3};
        for (int i = 0; i < FRAME_WORDS; i++) begin
            if (i % (N + 1) == 0) fr[f][i] = dg[i / (N + 1)];
            else                  fr[f][i] = (base == 0) ? '0 : DATA_W'(base + i);
        end
    endtask

    function automatic logic [N*DATA_W-1:0] row_of(input int f, input int r);
        return {fr[f][r*N+3], fr[f][r*N+2], fr[f][r*N+1], fr[f][r*N]};
    endfunction

    task automatic send_frame(input int f);
        for (int i = 0; i < FRAME_WORDS; i++) begin
            in_valid = 1'b1;
            in_data  = fr[f][i];
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_last, det_valid, overrun, frame_err} !== 5'b0 || out_row !== '0
            || out_row_idx !== '0 || det !== '0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b row=%h idx=%0d det=%h, required all zero",
                     {out_valid, out_last, det_valid, overrun, frame_err}, out_row, out_row_idx, det);
        end
    endtask

    task automatic test_single_frame();
        logic [N*DATA_W-1:0] exp_rows [4];
        exp_rows = '{48'h000000000008, 48'h000000010000, 48'h000018000000, 48'h020000000000};
        do_reset();
        set_frame(0, 12'd8, 12'd16, 12'd24, 12'd32, 0);
        out_ready = 1'b1;
        send_frame(0);
        checks++;
        if (det_valid !== 1'b1 || det !== 48'd98304) begin
            errors++;
            $display("FAIL single_det: valid=%b det=%0d, required 1 and 98304", det_valid, det);
        end
        checks++;
        if (out_valid !== 1'b1 || out_row_idx !== 2'd0 || out_row !== exp_rows[0]) begin
            errors++;
            $display("FAIL single_row0_latency: valid=%b idx=%0d row=%h, required 1 0 %h",
                     out_valid, out_row_idx, out_row, exp_rows[0]);
        end
        step();
        checks++;
        if (det_valid !== 1'b0 || det !== 48'd98304) begin
            errors++;
            $display("FAIL single_det_pulse: valid=%b det=%0d, required 0 and held 98304", det_valid, det);
        end
        step(); step(); step();
        checks++;
        if (rows_q.size() != 4 || out_valid !== 1'b0 || det_cnt != 1) begin
            errors++;
            $display("FAIL single_counts: rows=%0d valid=%b dets=%0d, required 4 0 1",
                     rows_q.size(), out_valid, det_cnt);
        end else begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (rows_q[r] !== exp_rows[r] || ridx_q[r] !== 2'(r) || rlast_q[r] !== (r == 3)) begin
                    errors++;
                    $display("FAIL single_row%0d: row=%h idx=%0d last=%b, required %h %0d %b",
                             r, rows_q[r], ridx_q[r], rlast_q[r], exp_rows[r], r, r == 3);
                end
            end
        end
    endtask

    task automatic test_negative_det();
        do_reset();
        set_frame(0, 12'hFF8, 12'd16, 12'd12, 12'd8, 100);
        out_ready = 1'b1;
        send_frame(0);
        checks++;
        if (det_valid !== 1'b1 || det !== 48'hFFFF_FFFF_D000) begin
            errors++;
            $display("FAIL negative_det: valid=%b det=%h, required 1 and ffffffffd000", det_valid, det);
        end
        step(); step(); step(); step();
        checks++;
        if (rows_q.size() != 4) begin
            errors++;
            $display("FAIL negative_rowcount: rows=%0d, required 4", rows_q.size());
        end else begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (rows_q[r] !== row_of(0, r)) begin
                    errors++;
                    $display("FAIL negative_row%0d: row=%h, required %h", r, rows_q[r], row_of(0, r));
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        set_frame(0, 12'd8,  12'd8, 12'd8, 12'd8, 300);
        set_frame(1, 12'd16, 12'd8, 12'd8, 12'd8, 400);
        set_frame(2, 12'd24, 12'd8, 12'd8, 12'd8, 200);
        out_ready = 1'b0;
        send_frame(0);
        send_frame(1);
        send_frame(2);
        checks++;
        if (det_cnt != 2 || det_seen !== 48'd8192 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flags: dets=%0d last_det=%0d overrun=%b, required 2 8192 1",
                     det_cnt, det_seen, overrun);
        end
        checks++;
        if (out_valid !== 1'b1 || out_row_idx !== 2'd0 || out_row !== row_of(0, 0)) begin
            errors++;
            $display("FAIL overrun_hold: valid=%b idx=%0d row=%h, required 1 0 %h",
                     out_valid, out_row_idx, out_row, row_of(0, 0));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (rows_q.size() != 8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drain: rows=%0d valid=%b, required 8 0", rows_q.size(), out_valid);
        end else begin
            for (int r = 0; r < 8; r++) begin
                checks++;
                if (rows_q[r] !== row_of(r / 4, r % 4)) begin
                    errors++;
                    $display("FAIL overrun_row%0d: row=%h, required %h", r, rows_q[r], row_of(r / 4, r % 4));
                end
            end
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        set_frame(0, 12'd8, 12'd16, 12'd24, 12'd32, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = fr[0][i];
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        step();
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_flag: frame_err=%b, required 1", frame_err);
        end
        step(); step(); step();
        checks++;
        if (out_valid !== 1'b0 || det_cnt != 0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_quiet: valid=%b dets=%0d overrun=%b, required 0 0 0",
                     out_valid, det_cnt, overrun);
        end
        send_frame(0);
        checks++;
        if (det_valid !== 1'b1 || det !== 48'd98304 || out_row !== row_of(0, 0)) begin
            errors++;
            $display("FAIL frame_err_recover: dv=%b det=%0d row=%h, required 1 98304 %h",
                     det_valid, det, out_row, row_of(0, 0));
        end
        step(); step(); step(); step();
        checks++;
        if (rows_q.size() != 4 || rows_q[3] !== 48'h020000000000 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_rows: rows=%0d frame_err=%b, required 4 rows ending 020000000000 and sticky 1",
                     rows_q.size(), frame_err);
        end
    endtask

    task automatic test_back_to_back();
        logic                prev_valid;
        logic                prev_ready;
        logic [N*DATA_W-1:0] prev_row;
        logic [ROW_W-1:0]    prev_idx;
        do_reset();
        set_frame(0, 12'd8,  12'd8,  12'd8, 12'd8, 500);
        set_frame(1, 12'd16, 12'd8,  12'd8, 12'd8, 600);
        set_frame(2, 12'd8,  12'd16, 12'd8, 12'd8, 700);
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_row   = '0;
        prev_idx   = '0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FRAME_WORDS; i++) begin
                if (prev_valid && !prev_ready) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_row !== prev_row || out_row_idx !== prev_idx) begin
                        errors++;
                        $display("FAIL b2b_stall_hold: valid=%b row=%h idx=%0d, required 1 %h %0d",
                                 out_valid, out_row, out_row_idx, prev_row, prev_idx);
                    end
                end
                // Last-row handshake of the previous frame lands on this frame's word 15.
                out_ready  = (i >= 9) && (i % 2 == 1);
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_row   = out_row;
                prev_idx   = out_row_idx;
                in_valid   = 1'b1;
                in_data    = fr[f][i];
                step();
            end
            if (f > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_row_idx !== 2'd0 || out_row !== row_of(f, 0)) begin
                    errors++;
                    $display("FAIL b2b_commit_free_f%0d: valid=%b idx=%0d row=%h, required 1 0 %h",
                             f, out_valid, out_row_idx, out_row, row_of(f, 0));
                end
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 0; k < 8; k++) begin
            if (prev_valid && !prev_ready) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== prev_row || out_row_idx !== prev_idx) begin
                    errors++;
                    $display("FAIL b2b_drain_hold: valid=%b row=%h idx=%0d, required 1 %h %0d",
                             out_valid, out_row, out_row_idx, prev_row, prev_idx);
                end
            end
            out_ready  = (k % 2 == 0);
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_row   = out_row;
            prev_idx   = out_row_idx;
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0 || det_cnt != 3
            || rows_q.size() != 12) begin
            errors++;
            $display("FAIL b2b_summary: valid=%b overrun=%b frame_err=%b dets=%0d rows=%0d, required 0 0 0 3 12",
                     out_valid, overrun, frame_err, det_cnt, rows_q.size());
        end else begin
            for (int r = 0; r < 12; r++) begin
                checks++;
                if (rows_q[r] !== row_of(r / 4, r % 4)) begin
                    errors++;
                    $display("FAIL b2b_row%0d: row=%h, required %h", r, rows_q[r], row_of(r / 4, r % 4));
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        set_frame(0, 12'd8,  12'd16, 12'd24, 12'd32, 0);
        set_frame(1, 12'd16, 12'd16, 12'd16, 12'd16, 800);
        out_ready = 1'b0;
        send_frame(0);
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_row_idx !== 2'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL middrain_position: idx=%0d valid=%b, required 2 1", out_row_idx, out_valid);
        end
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step();
        checks++;
        if ({out_valid, out_last, det_valid, overrun, frame_err} !== 5'b0 || out_row !== '0
            || out_row_idx !== '0 || det !== '0) begin
            errors++;
            $display("FAIL middrain_reset: flags=%b row=%h idx=%0d det=%h, required all zero",
                     {out_valid, out_last, det_valid, overrun, frame_err}, out_row, out_row_idx, det);
        end
        rst_n = 1'b1;
        clear_log();
        out_ready = 1'b1;
        send_frame(1);
        checks++;
        if (out_row_idx !== 2'd0 || out_row !== row_of(1, 0) || det !== 48'd65536) begin
            errors++;
            $display("FAIL middrain_newframe: idx=%0d row=%h det=%0d, required 0 %h 65536",
                     out_row_idx, out_row, det, row_of(1, 0));
        end
        step(); step(); step(); step();
        checks++;
        if (rows_q.size() != 4 || rows_q[0] !== row_of(1, 0) || rows_q[3] !== row_of(1, 3)) begin
            errors++;
            $display("FAIL middrain_rows: rows=%0d, required 4 rows of the new frame", rows_q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_negative_det();
        test_overrun();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
